// File: rtl/store_write_buffer_if.sv
//==============================================================================
// Module      : store_write_buffer_if
// Description : Store, load-check and memory-drain bundle of the store buffer.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface store_write_buffer_if #(
    parameter int PTR_W = 2
) ();
    logic             st_valid;
    logic             st_ready;
    logic [31:0]      st_addr;
    logic [31:0]      st_data;
    logic [1:0]       st_size;
    logic             ld_valid;
    logic [31:0]      ld_addr;
    logic [1:0]       ld_size;
    logic             ld_hazard;
    logic             mem_grant;
    logic             mem_write;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic [1:0]       mem_size;
    logic [PTR_W:0]   count;
    logic             empty;

    modport master (
        output st_valid, st_addr, st_data, st_size,
        output ld_valid, ld_addr, ld_size, mem_grant,
        input  st_ready, ld_hazard, mem_write, mem_addr, mem_wdata, mem_size,
        input  count, empty
    );

    modport slave (
        input  st_valid, st_addr, st_data, st_size,
        input  ld_valid, ld_addr, ld_size, mem_grant,
        output st_ready, ld_hazard, mem_write, mem_addr, mem_wdata, mem_size,
        output count, empty
    );
endinterface

`default_nettype wire

// File: rtl/store_write_buffer.sv
//==============================================================================
// Module      : store_write_buffer
// Description : Posted-store FIFO ahead of the data memory with load-overlap check.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module store_write_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    store_write_buffer_if.slave bus
);
    localparam logic [PTR_W:0] C_DEPTH = (PTR_W+1)'(DEPTH);

    logic [31:0]      addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [1:0]       size_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;

    logic             w_empty;
    logic             w_ready;
    logic             w_push;
    logic             w_pop;
    logic [32:0]      w_ld_lo;
    logic [32:0]      w_ld_end;
    logic [DEPTH-1:0] w_hit;

    function automatic logic [32:0] byte_len(input logic [1:0] sz);
        case (sz)
            2'b11:   byte_len = 33'd4;
            2'b10:   byte_len = 33'd2;
            2'b01:   byte_len = 33'd1;
            default: byte_len = 33'd0;
        endcase
    endfunction

    assign w_empty = (count_q == '0);
    assign w_ready = (count_q < C_DEPTH);
    assign w_push  = bus.st_valid && w_ready && (bus.st_size != 2'b00);
    assign w_pop   = !w_empty && bus.mem_grant;

    // 33-bit interval ends keep ranges touching 0xFFFFFFFF from wrapping to 0
    assign w_ld_lo  = {1'b0, bus.ld_addr};
    assign w_ld_end = w_ld_lo + byte_len(bus.ld_size);

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_slot
            logic [PTR_W-1:0] w_off;
            logic [32:0]      w_lo;
            logic [32:0]      w_end;

            assign w_off    = PTR_W'(i) - head_q;
            assign w_lo     = {1'b0, addr_q[i]};
            assign w_end    = w_lo + byte_len(size_q[i]);
            assign w_hit[i] = ({1'b0, w_off} < count_q) && (w_lo < w_ld_end) && (w_ld_lo < w_end);
        end
    endgenerate

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (w_push) begin
            tail_d = tail_q + PTR_W'(1);
        end
        if (w_pop) begin
            head_d = head_q + PTR_W'(1);
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload needs no reset: slots are only observed while counted valid
    always_ff @(posedge clk) begin
        if (w_push) begin
            addr_q[tail_q] <= bus.st_addr;
            data_q[tail_q] <= bus.st_data;
            size_q[tail_q] <= bus.st_size;
        end
    end

    assign bus.st_ready  = w_ready;
    assign bus.empty     = w_empty;
    assign bus.count     = count_q;
    assign bus.mem_write = w_pop;
    assign bus.mem_addr  = w_empty ? 32'd0 : addr_q[head_q];
    assign bus.mem_wdata = w_empty ? 32'd0 : data_q[head_q];
    assign bus.mem_size  = w_empty ? 2'd0  : size_q[head_q];
    assign bus.ld_hazard = bus.ld_valid && (|w_hit);

endmodule

`default_nettype wire
